// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;
    localparam int DIV_WIDTH = 4;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring step: shift in a dividend bit, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    assign shifted = {rem_in, bit_in};
    assign trial   = shifted - {2'b00, divisor};
    // Partial remainder is always below the divisor, so the top trial bit is a clean borrow flag.
    assign q_bit   = ~trial[WIDTH+1];
    assign rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider: WIDTH-cycle result (1 cycle on divide-by-zero), start taken in IDLE/DONE, ignored while busy.
// SIGNED_DIV_EN selects two's complement operands/results; the default build is unsigned only.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] dsr;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   st_rem_in;
    logic [WIDTH:0]   st_rem_out;
    logic [WIDTH-1:0] st_div;
    logic             st_bit;
    logic             st_q;
    logic             loading;
    logic [WIDTH-1:0] q_u;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

`ifdef SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;

    assign a_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign b_mag = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
    assign res_q = neg_q ? (~q_u + WIDTH'(1)) : q_u;
    assign res_r = neg_r ? (~st_rem_out[WIDTH-1:0] + WIDTH'(1)) : st_rem_out[WIDTH-1:0];
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign res_q = q_u;
    assign res_r = st_rem_out[WIDTH-1:0];
`endif

    // The accepting edge already performs step 0 on the incoming operands, so RUN lasts WIDTH-1 cycles.
    assign loading   = (state != RUN);
    assign st_rem_in = loading ? '0 : prem;
    assign st_bit    = loading ? a_mag[WIDTH-1] : shreg[WIDTH-1];
    assign st_div    = loading ? b_mag : dsr;
    assign q_u       = {shreg[WIDTH-2:0], st_q};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (st_rem_in),
        .bit_in  (st_bit),
        .divisor (st_div),
        .rem_out (st_rem_out),
        .q_bit   (st_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            prem        <= '0;
            shreg       <= '0;
            dsr         <= '0;
`ifdef SIGNED_DIV_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            prem  <= st_rem_out;
                            shreg <= {a_mag[WIDTH-2:0], st_q};
                            dsr   <= b_mag;
                            cnt   <= CNT_W'(1);
`ifdef SIGNED_DIV_EN
                            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r <= dividend[WIDTH-1];
`endif
                        end
                    end
                end
                RUN: begin
                    prem  <= st_rem_out;
                    shreg <= q_u;
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= res_q;
                        remainder   <= res_r;
                        div_by_zero <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (WIDTH=4) with a cycle-level reference model and literal checks.
module tb_restoring_divider;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;

    int n_vec = 0;
    int n_bad = 0;

    restoring_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] q, output logic [3:0] r, output logic z);
        if (b == 4'd0) begin
            q = 4'hF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            int sa, sb;
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 4'(sa / sb);
            r  = 4'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
            z = 1'b0;
        end
    endfunction

    // Transaction-level timing model: edge index of acceptance, busy window, done edge.
    int         ecnt = 0;
    int         busy_lo = 0, busy_hi = -1, done_edge = -1, free_edge = 0;
    logic [3:0] pend_q, pend_r, cur_q = '0, cur_r = '0;
    logic       pend_z, cur_z = 1'b0;

    always @(posedge clk) begin
        ecnt++;
        if (rst) begin
            busy_hi = -1;
            done_edge = -1;
            free_edge = 0;
            cur_q = '0;
            cur_r = '0;
            cur_z = 1'b0;
        end else begin
            if (start && ecnt >= free_edge) begin
                model(dividend, divisor, pend_q, pend_r, pend_z);
                busy_lo   = ecnt;
                busy_hi   = (divisor == 4'd0) ? ecnt - 1 : ecnt + 2;
                done_edge = (divisor == 4'd0) ? ecnt : ecnt + 3;
                free_edge = done_edge + 1;
            end
            if (ecnt == done_edge) begin
                cur_q = pend_q;
                cur_r = pend_r;
                cur_z = pend_z;
            end
        end
    end

    always @(negedge clk) begin
        if (ecnt > 0) begin
            chk("m_busy", 8'(busy), 8'(ecnt >= busy_lo && ecnt <= busy_hi));
            chk("m_done", 8'(done), 8'(ecnt == done_edge));
            chk("m_quot", 8'(quotient), 8'(cur_q));
            chk("m_rem", 8'(remainder), 8'(cur_r));
            chk("m_dbz", 8'(div_by_zero), 8'(cur_z));
        end
    end

    task automatic wait_done(output int n, output int nb, output bit seen);
        n = 0;
        nb = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) seen = 1'b1;
        end
        chk("done_seen", 8'(seen), 8'd1);
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                         input logic [3:0] er, input logic ez, input int elat, input int ebusy);
        int n, nb;
        bit seen;
        @(posedge clk); #1;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, nb, seen);
        chk("latency", 8'(n), 8'(elat));
        chk("busy_cycles", 8'(nb), 8'(ebusy));
        chk("quotient", 8'(quotient), 8'(eq));
        chk("remainder", 8'(remainder), 8'(er));
        chk("div_by_zero", 8'(div_by_zero), 8'(ez));
    endtask

`ifdef SIGNED_DIV_EN
    logic [3:0] ta[4] = '{4'd15, 4'd0, 4'd5, 4'd8};
    logic [3:0] tb[4] = '{4'd15, 4'd5, 4'd7, 4'd3};
    logic [3:0] tq[4] = '{4'd1,  4'd0, 4'd0, 4'hE};
    logic [3:0] tr[4] = '{4'd0,  4'd0, 4'd5, 4'hE};
`else
    logic [3:0] ta[4] = '{4'd15, 4'd0, 4'd5, 4'd8};
    logic [3:0] tb[4] = '{4'd15, 4'd5, 4'd7, 4'd3};
    logic [3:0] tq[4] = '{4'd1,  4'd0, 4'd0, 4'd2};
    logic [3:0] tr[4] = '{4'd0,  4'd0, 4'd5, 4'd2};
`endif

    initial begin
        int n, nb;
        bit seen;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_quot", 8'(quotient), 8'd0);
        chk("rst_rem", 8'(remainder), 8'd0);
        chk("rst_dbz", 8'(div_by_zero), 8'd0);

`ifdef SIGNED_DIV_EN
        do_op(4'd13, 4'd3, 4'hF, 4'd0, 1'b0, 4, 3);
`else
        do_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4, 3);
`endif
        do_op(4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 1, 0);

        // Back-to-back with start held high.
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd15; divisor = 4'd1;
        @(posedge clk);
        wait_done(n, nb, seen);
        chk("b2b_lat1", 8'(n), 8'd4);
        chk("b2b_q1", 8'(quotient), 8'd15);
        chk("b2b_r1", 8'(remainder), 8'd0);
        dividend = 4'd9; divisor = 4'd4;
        wait_done(n, nb, seen);
        start = 1'b0;
        chk("b2b_gap", 8'(n), 8'd4);
`ifdef SIGNED_DIV_EN
        chk("b2b_q2", 8'(quotient), 8'hF);
        chk("b2b_r2", 8'(remainder), 8'hD);
`else
        chk("b2b_q2", 8'(quotient), 8'd2);
        chk("b2b_r2", 8'(remainder), 8'd1);
`endif

        // Start pulse during RUN must be ignored.
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, nb, seen);
        chk("ign_lat", 8'(n), 8'd2);
`ifdef SIGNED_DIV_EN
        chk("ign_q", 8'(quotient), 8'd0);
        chk("ign_r", 8'(remainder), 8'hC);
`else
        chk("ign_q", 8'(quotient), 8'd2);
        chk("ign_r", 8'(remainder), 8'd2);
`endif

        // Reset on the third RUN cycle.
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_done", 8'(done), 8'd0);
        chk("mid_rst_quot", 8'(quotient), 8'd0);
        chk("mid_rst_rem", 8'(remainder), 8'd0);
        chk("mid_rst_dbz", 8'(div_by_zero), 8'd0);
        do_op(4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 4, 3);

        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], tq[i], tr[i], 1'b0, 4, 3);
        end

`ifdef SIGNED_DIV_EN
        do_op(4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 4, 3);
        do_op(4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0, 4, 3);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
